// File: rtl/data_obi_arbiter_pkg.sv
// data_obi_arbiter_pkg: shared types for the two-master data OBI arbiter.
package data_obi_arbiter_pkg;
    localparam int DOBI_NPORTS = 2;
    localparam int DOBI_DW     = 33;

    typedef logic arb_id_t;

    typedef struct packed {
        logic                we;
        logic [3:0]          be;
        logic                is_cap;
        logic [31:0]         addr;
        logic [DOBI_DW-1:0]  wdata;
    } obi_req_t;
endpackage

// File: rtl/data_obi_arbiter_if.sv
// data_obi_arbiter_if: OBI data bus with NP request lanes and one shared response lane.
interface data_obi_arbiter_if #(parameter int NP = 1);
    import data_obi_arbiter_pkg::*;
    logic [NP-1:0]               req;
    logic [NP-1:0]               we;
    logic [NP-1:0][3:0]          be;
    logic [NP-1:0]               is_cap;
    logic [NP-1:0][31:0]         addr;
    logic [NP-1:0][DOBI_DW-1:0]  wdata;
    logic [NP-1:0]               gnt;
    logic [NP-1:0]               rvalid;
    logic [DOBI_DW-1:0]          rdata;
    logic                        err;

    modport master (output req, we, be, is_cap, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, be, is_cap, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/data_obi_arbiter_outs_fifo.sv
// data_obi_arbiter_outs_fifo: in-order FIFO of port ids for granted, unanswered transactions.
module data_obi_arbiter_outs_fifo
    import data_obi_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_push,
    input  arb_id_t i_push_id,
    input  logic    i_pop,
    output arb_id_t o_head,
    output logic    o_full,
    output logic    o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    arb_id_t         r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_id;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
endmodule

// File: rtl/data_obi_arbiter.sv
// data_obi_arbiter: shares one data OBI slave between CPU LSU (port 0) and aux master (port 1).
// Define DOBI_ARB_RR_EN for round-robin contention; default is fixed priority to port 0.
module data_obi_arbiter
    import data_obi_arbiter_pkg::*;
#(
    parameter int MAX_OUTS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    data_obi_arbiter_if.slave   i_mst,
    data_obi_arbiter_if.master  o_slv,
    output logic                o_arb_proto_err
);
    arb_id_t  w_winner;
    arb_id_t  w_sel;
    arb_id_t  w_head;
    arb_id_t  r_lock_id;
    logic     r_lock;
    logic     r_proto_err;
    logic     w_full;
    logic     w_empty;
    logic     w_sreq;
    logic     w_hs;
    logic     w_rv;
    logic     w_pop;
    obi_req_t w_sel_req;

`ifdef DOBI_ARB_RR_EN
    arb_id_t r_last_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_last_id <= 1'b1;
        else if (w_hs) r_last_id <= w_sel;
    end

    assign w_winner = (&i_mst.req) ? ~r_last_id : ~i_mst.req[0];
`else
    assign w_winner = ~i_mst.req[0];
`endif

    // a pending address phase stays on the bus until it is granted
    assign w_sel     = r_lock ? r_lock_id : w_winner;
    assign w_sel_req = '{we: i_mst.we[w_sel], be: i_mst.be[w_sel], is_cap: i_mst.is_cap[w_sel],
                         addr: i_mst.addr[w_sel], wdata: i_mst.wdata[w_sel]};

    assign w_sreq          = rst_n & i_mst.req[w_sel] & ~w_full;
    assign w_hs            = w_sreq & o_slv.gnt[0];
    assign o_slv.req       = w_sreq;
    assign o_slv.we        = w_sel_req.we;
    assign o_slv.be        = w_sel_req.be;
    assign o_slv.is_cap    = w_sel_req.is_cap;
    assign o_slv.addr      = w_sel_req.addr;
    assign o_slv.wdata     = w_sel_req.wdata;
    assign i_mst.gnt       = {w_hs & w_sel, w_hs & ~w_sel};

    assign w_rv            = rst_n & o_slv.rvalid[0];
    assign w_pop           = w_rv & ~w_empty;
    assign i_mst.rvalid    = {w_pop & w_head, w_pop & ~w_head};
    assign i_mst.rdata     = w_rv ? o_slv.rdata : '0;
    assign i_mst.err       = w_rv & o_slv.err;
    assign o_arb_proto_err = r_proto_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock      <= 1'b0;
            r_lock_id   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_lock <= w_sreq & ~o_slv.gnt[0];
            if (w_sreq & ~o_slv.gnt[0]) r_lock_id <= w_sel;
            if (w_rv & w_empty) r_proto_err <= 1'b1;
        end
    end

    data_obi_arbiter_outs_fifo #(.DEPTH(MAX_OUTS)) u_outs_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_hs),
        .i_push_id (w_sel),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );
endmodule

// File: tb/tb_data_obi_arbiter.sv
// tb_data_obi_arbiter: directed scoreboard bench for data_obi_arbiter.
module tb_data_obi_arbiter;
    import data_obi_arbiter_pkg::*;

`ifdef DOBI_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit          port;
        logic [32:0] data;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    logic proto;
    exp_t sb[$];
    int   vec;
    int   miss;
    int   tag;

    data_obi_arbiter_if #(.NP(DOBI_NPORTS)) m_if ();
    data_obi_arbiter_if #(.NP(1))           s_if ();

    data_obi_arbiter #(.MAX_OUTS(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_mst           (m_if),
        .o_slv           (s_if),
        .o_arb_proto_err (proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_if.req    = '0;
        s_if.gnt    = '0;
        s_if.rvalid = '0;
        s_if.rdata  = '0;
        s_if.err    = 1'b0;
    endtask

    task automatic master(input bit p, input logic [31:0] a, input logic we);
        m_if.req[p]    = 1'b1;
        m_if.addr[p]   = a;
        m_if.we[p]     = we;
        m_if.be[p]     = 4'hF;
        m_if.wdata[p]  = {1'b0, a ^ 32'hA5A5_0000};
    endtask

    task automatic push(input bit p, input logic err);
        tag++;
        sb.push_back('{p, {1'b1, 32'hC0DE_0000 + 32'(tag)}, err});
    endtask

    task automatic rsp();
        exp_t e;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        s_if.rvalid = 1'b1;
        s_if.rdata  = e.data;
        s_if.err    = e.err;
        #1;
        chk("rsp_rvalid", m_if.rvalid, e.port ? 64'd2 : 64'd1);
        chk("rsp_rdata", m_if.rdata, e.data);
        chk("rsp_err", m_if.err, e.err);
    endtask

    task automatic reset_pulse();
        step();
        idle();
        rst_n = 1'b0;
        sb.delete();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        bit p;
        vec = 0;
        miss = 0;
        tag = 0;
        rst_n = 1'b0;
        m_if.we = '0;
        m_if.be = '0;
        m_if.is_cap = '0;
        m_if.addr = '0;
        m_if.wdata = '0;
        idle();
        m_if.req = 2'b11;
        s_if.gnt = 1'b1;
        s_if.rvalid = 1'b1;
        s_if.rdata = 33'h1_2345_6789;
        repeat (2) step();
        chk("rst_sreq", s_if.req, 0);
        chk("rst_mgnt", m_if.gnt, 0);
        chk("rst_mrvalid", m_if.rvalid, 0);
        chk("rst_mrdata", m_if.rdata, 0);
        chk("rst_proto", proto, 0);
        idle();
        step();
        rst_n = 1'b1;

        // single master, grant after two wait cycles
        step();
        master(0, 32'h8000_0100, 1'b0);
        #1;
        chk("single_sreq", s_if.req, 1);
        chk("single_saddr0", s_if.addr, 32'h8000_0100);
        chk("single_gnt0", m_if.gnt, 0);
        step();
        #1;
        chk("single_saddr1", s_if.addr, 32'h8000_0100);
        chk("single_gnt1", m_if.gnt, 0);
        step();
        s_if.gnt = 1'b1;
        #1;
        chk("single_gnt2", m_if.gnt, 1);
        sb.push_back('{1'b0, 33'h1_DEAD_BEEF, 1'b0});
        step();
        idle();
        rsp();
        step();
        idle();
        #1;
        chk("single_idle_rvalid", m_if.rvalid, 0);
        chk("single_idle_rdata", m_if.rdata, 0);

        // contention until full, then one response reopens the port
        reset_pulse();
        step();
        master(0, 32'h0000_1000, 1'b1);
        master(1, 32'h0000_2000, 1'b0);
        s_if.gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            #1;
            p = RR ? i[0] : 1'b0;
            chk("cont_gnt", m_if.gnt, p ? 64'd2 : 64'd1);
            chk("cont_saddr", s_if.addr, p ? 64'h2000 : 64'h1000);
            chk("cont_swe", s_if.we, p ? 64'd0 : 64'd1);
            push(p, 1'b0);
        end
        step();
        #1;
        chk("full_sreq", s_if.req, 0);
        chk("full_gnt", m_if.gnt, 0);
        step();
        rsp();
        chk("full_pop_sreq", s_if.req, 0);
        chk("full_pop_gnt", m_if.gnt, 0);
        step();
        s_if.rvalid = 1'b0;
        s_if.rdata = '0;
        #1;
        chk("full_resume_gnt", m_if.gnt, 1);
        push(1'b0, 1'b0);
        step();
        idle();
        rsp();
        repeat (3) begin
            step();
            rsp();
        end

        // lock: port1 waits on s_gnt while port0 arrives
        step();
        idle();
        master(1, 32'h0000_3000, 1'b0);
        #1;
        chk("lock_saddr0", s_if.addr, 32'h3000);
        chk("lock_gnt0", m_if.gnt, 0);
        step();
        master(0, 32'h0000_4000, 1'b0);
        #1;
        chk("lock_saddr1", s_if.addr, 32'h3000);
        step();
        #1;
        chk("lock_saddr2", s_if.addr, 32'h3000);
        step();
        s_if.gnt = 1'b1;
        #1;
        chk("lock_gnt_p1", m_if.gnt, 2);
        push(1'b1, 1'b1);
        step();
        m_if.req[1] = 1'b0;
        #1;
        chk("lock_gnt_p0", m_if.gnt, 1);
        chk("lock_saddr_p0", s_if.addr, 32'h4000);
        push(1'b0, 1'b0);
        step();
        idle();
        rsp();
        step();
        rsp();

        // response with nothing outstanding
        step();
        idle();
        s_if.rvalid = 1'b1;
        s_if.rdata = 33'h0_1111_2222;
        #1;
        chk("proto_rvalid", m_if.rvalid, 0);
        chk("proto_pre", proto, 0);
        step();
        s_if.rvalid = 1'b0;
        #1;
        chk("proto_set", proto, 1);
        repeat (3) step();
        chk("proto_sticky", proto, 1);

        // reset with two transactions in flight
        step();
        master(0, 32'h0000_5000, 1'b0);
        s_if.gnt = 1'b1;
        step();
        step();
        s_if.rvalid = 1'b1;
        s_if.rdata = 33'h1_5555_AAAA;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_sreq", s_if.req, 0);
        chk("mid_rst_gnt", m_if.gnt, 0);
        chk("mid_rst_rvalid", m_if.rvalid, 0);
        chk("mid_rst_rdata", m_if.rdata, 0);
        chk("mid_rst_proto", proto, 0);
        step();
        idle();
        rst_n = 1'b1;
        step();
        s_if.rvalid = 1'b1;
        s_if.rdata = 33'h0_0000_0007;
        #1;
        chk("post_rst_rvalid", m_if.rvalid, 0);
        step();
        idle();
        #1;
        chk("post_rst_proto", proto, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
